fetch_queue: RTL and testbench

- Decoupled instruction-fetch front end between the instruction memory port and id_stage.
- Issues sequential fetch requests, buffers returned words with their PCs in an in-order queue, and presents one instruction per cycle to decode.
- Absorbs decode stalls and variable memory latency.
- On an EX-stage branch redirect, flushes the queue and discards in-flight responses.

---
 rtl/fetch_queue_if.sv | 26 ++
 rtl/fetch_queue.sv | 81 ++++++++
 tb/tb_fetch_queue.sv | 281 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/fetch_queue_if.sv
// fetch_queue_if: memory request/response, decode-side and redirect signals of fetch_queue.
// master is the fetch_queue side; slave is the memory/decode/branch environment.
interface fetch_queue_if #(
    parameter int DEPTH = 4
);
    logic                     req_valid_o;
    logic                     req_ready_i;
    logic [31:0]              req_addr_o;
    logic                     resp_valid_i;
    logic [31:0]              resp_data_i;
    logic                     redirect_i;
    logic [31:0]              redirect_pc_i;
    logic                     stall_i;
    logic                     valid_o;
    logic [31:0]              instr_o;
    logic [31:0]              pc_o;
    logic [$clog2(DEPTH):0]   outstanding_o;
    modport master (
        output req_valid_o, req_addr_o, valid_o, instr_o, pc_o, outstanding_o,
        input  req_ready_i, resp_valid_i, resp_data_i, redirect_i, redirect_pc_i, stall_i
    );
    modport slave (
        input  req_valid_o, req_addr_o, valid_o, instr_o, pc_o, outstanding_o,
        output req_ready_i, resp_valid_i, resp_data_i, redirect_i, redirect_pc_i, stall_i
    );
endinterface

// File: rtl/fetch_queue.sv
// fetch_queue: decoupled instruction fetch queue with credit-based request issue and redirect flush.
// Define FETCH_QUEUE_BYPASS_EN to present an undiscarded response the same cycle when the queue is empty.
module fetch_queue #(
    parameter int          DEPTH     = 4,
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input logic           clk,
    input logic           rst,
    fetch_queue_if.master bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW:0]   CREDIT = (CW + 1)'(DEPTH);
    localparam logic [CW-1:0] FULL   = CW'(DEPTH);
    logic [31:0]   q_instr [DEPTH];
    logic [31:0]   q_pc    [DEPTH];
    logic [AW-1:0] rd_ptr, wr_ptr;
    logic [CW-1:0] count, outstanding, drop_cnt;
    logic [31:0]   fetch_pc, resp_pc, target_pc;
    logic          empty, hs, resp_take, resp_keep, bypass, push, pop;
    // Responses with nothing outstanding belong to requests killed by reset and are ignored.
    always_comb begin
        empty             = count == '0;
        target_pc         = {bus.redirect_pc_i[31:2], 2'b00};
        bus.req_valid_o   = !rst && !bus.redirect_i && ({1'b0, count} + {1'b0, outstanding} < CREDIT);
        bus.req_addr_o    = fetch_pc;
        hs                = bus.req_valid_o && bus.req_ready_i;
        resp_take         = bus.resp_valid_i && outstanding != '0;
        resp_keep         = resp_take && !bus.redirect_i && drop_cnt == '0;
`ifdef FETCH_QUEUE_BYPASS_EN
        bypass            = resp_keep && empty;
`else
        bypass            = 1'b0;
`endif
        push              = resp_keep && !(bypass && !bus.stall_i);
        pop               = !empty && !bus.stall_i;
        bus.valid_o       = !empty || bypass;
        bus.instr_o       = !empty ? q_instr[rd_ptr] : bypass ? bus.resp_data_i : NOP_INSTR;
        bus.pc_o          = !empty ? q_pc[rd_ptr] : bypass ? resp_pc : '0;
        bus.outstanding_o = outstanding;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr      <= '0;
            wr_ptr      <= '0;
            count       <= '0;
            outstanding <= '0;
            drop_cnt    <= '0;
            fetch_pc    <= RESET_PC;
            resp_pc     <= RESET_PC;
        end else begin
            outstanding <= outstanding + CW'(hs) - CW'(resp_take);
            if (bus.redirect_i) begin
                rd_ptr   <= '0;
                wr_ptr   <= '0;
                count    <= '0;
                drop_cnt <= outstanding - CW'(resp_take);
                fetch_pc <= target_pc;
                resp_pc  <= target_pc;
            end else begin
                if (hs) fetch_pc <= fetch_pc + 32'd4;
                if (resp_take && drop_cnt != '0) drop_cnt <= drop_cnt - CW'(1);
                if (resp_keep) resp_pc <= resp_pc + 32'd4;
                if (push) wr_ptr <= wr_ptr + AW'(1);
                if (pop) rd_ptr <= rd_ptr + AW'(1);
                count <= count + CW'(push) - CW'(pop);
            end
        end
    end
    always_ff @(posedge clk) begin
        if (!rst && push) begin
            q_instr[wr_ptr] <= bus.resp_data_i;
            q_pc[wr_ptr]    <= resp_pc;
        end
    end
    // The credit rule reserves a slot for every in-flight request, so a full queue never sees a push.
    always_ff @(posedge clk) begin
        if (!rst) assert (!(push && count == FULL));
    end
endmodule

// File: tb/tb_fetch_queue.sv
// tb_fetch_queue: scoreboard bench for fetch_queue with a latency-configurable memory returning addr as data.
module tb_fetch_queue;
    typedef struct {
        logic [31:0] addr;
        int          due;
    } mem_t;
    logic clk = 1'b0;
    logic rst = 1'b1;
    fetch_queue_if #(.DEPTH(4)) bus();
    fetch_queue #(.DEPTH(4), .RESET_PC(32'h0), .NOP_INSTR(32'h13)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );
    always #5 clk = ~clk;
    mem_t        mem_q[$];
    logic [31:0] exp_q[$];
    logic [31:0] model_pc = 32'h0;
    logic [31:0] first_pc;
    int          lat = 1;
    int          cyc = 0;
    int          first_cyc;
    int          pop_cnt;
    bit          got_valid;
    int          checks = 0;
    int          errors = 0;
`ifdef FETCH_QUEUE_BYPASS_EN
    localparam int EXP_FIRST = 1;
    localparam int EXP_POPS  = 11;
`else
    localparam int EXP_FIRST = 2;
    localparam int EXP_POPS  = 10;
`endif
    task automatic cycle();
        bus.resp_valid_i = 1'b0;
        bus.resp_data_i  = 32'h0;
        if (mem_q.size() > 0 && mem_q[0].due <= cyc) begin
            bus.resp_valid_i = 1'b1;
            bus.resp_data_i  = mem_q[0].addr;
            void'(mem_q.pop_front());
        end
        #1;
        if (rst) begin
            exp_q.delete();
            model_pc = 32'h0;
        end else begin
            if (bus.redirect_i) begin
                checks++;
                if (bus.req_valid_o !== 1'b0) begin
                    errors++;
                    $display("FAIL redirect_req_valid: got %b expected 0", bus.req_valid_o);
                end
            end
            if (bus.valid_o === 1'b1) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_valid: got pc %h expected no valid entry", bus.pc_o);
                end else if (bus.pc_o !== exp_q[0] || bus.instr_o !== exp_q[0]) begin
                    errors++;
                    $display("FAIL head: got pc %h instr %h expected %h", bus.pc_o, bus.instr_o, exp_q[0]);
                end
                if (!got_valid) begin
                    got_valid = 1'b1;
                    first_pc  = bus.pc_o;
                    first_cyc = cyc;
                end
                if (!bus.stall_i) begin
                    pop_cnt++;
                    if (exp_q.size() > 0) void'(exp_q.pop_front());
                end
            end
            if (bus.req_valid_o && bus.req_ready_i) begin
                checks++;
                if (bus.req_addr_o !== model_pc) begin
                    errors++;
                    $display("FAIL req_addr: got %h expected %h", bus.req_addr_o, model_pc);
                end
                mem_q.push_back('{addr: bus.req_addr_o, due: cyc + lat});
                exp_q.push_back(model_pc);
                model_pc = model_pc + 32'd4;
            end
            if (bus.redirect_i) begin
                exp_q.delete();
                model_pc = {bus.redirect_pc_i[31:2], 2'b00};
            end
        end
        @(posedge clk);
        cyc++;
        @(negedge clk);
    endtask
    task automatic do_reset();
        rst = 1'b1;
        bus.req_ready_i = 1'b0;
        bus.stall_i = 1'b0;
        bus.redirect_i = 1'b0;
        repeat (2) cycle();
        for (int i = 0; i < 10 && mem_q.size() > 0; i++) cycle();
        cycle();
        rst = 1'b0;
        bus.resp_valid_i = 1'b0;
        got_valid = 1'b0;
        pop_cnt = 0;
        #1;
    endtask
    task automatic test_reset();
        rst = 1'b1;
        bus.req_ready_i = 1'b0;
        #1;
        checks++;
        if (bus.req_valid_o !== 1'b0) begin
            errors++;
            $display("FAIL reset_req_valid: got %b expected 0", bus.req_valid_o);
        end
        do_reset();
        checks++;
        if (bus.valid_o !== 1'b0 || bus.instr_o !== 32'h13 || bus.pc_o !== 32'h0) begin
            errors++;
            $display("FAIL reset_outputs: got valid %b instr %h pc %h expected 0 00000013 00000000", bus.valid_o, bus.instr_o, bus.pc_o);
        end
        checks++;
        if (bus.req_addr_o !== 32'h0 || bus.outstanding_o !== 3'd0 || bus.req_valid_o !== 1'b1) begin
            errors++;
            $display("FAIL reset_req: got addr %h outstanding %0d req_valid %b expected 0 0 1", bus.req_addr_o, bus.outstanding_o, bus.req_valid_o);
        end
    endtask
    task automatic test_stream();
        do_reset();
        lat = 1;
        bus.req_ready_i = 1'b1;
        begin
            int c0 = cyc;
            repeat (12) cycle();
            checks++;
            if (!got_valid || first_cyc - c0 != EXP_FIRST) begin
                errors++;
                $display("FAIL first_valid_cycle: got %0d expected %0d", first_cyc - c0, EXP_FIRST);
            end
        end
        checks++;
        if (pop_cnt != EXP_POPS) begin
            errors++;
            $display("FAIL throughput: got %0d pops expected %0d", pop_cnt, EXP_POPS);
        end
    endtask
    task automatic test_stall();
        do_reset();
        lat = 1;
        bus.req_ready_i = 1'b1;
        bus.stall_i = 1'b1;
        repeat (10) cycle();
        #1;
        checks++;
        if (bus.valid_o !== 1'b1 || bus.pc_o !== 32'h0 || bus.instr_o !== 32'h0) begin
            errors++;
            $display("FAIL stall_head: got valid %b pc %h instr %h expected 1 0 0", bus.valid_o, bus.pc_o, bus.instr_o);
        end
        checks++;
        if (bus.req_valid_o !== 1'b0 || bus.outstanding_o !== 3'd0) begin
            errors++;
            $display("FAIL stall_full: got req_valid %b outstanding %0d expected 0 0", bus.req_valid_o, bus.outstanding_o);
        end
        bus.stall_i = 1'b0;
        pop_cnt = 0;
        cycle();
        #1;
        checks++;
        if (bus.req_valid_o !== 1'b1 || bus.req_addr_o !== 32'h10) begin
            errors++;
            $display("FAIL stall_resume: got req_valid %b addr %h expected 1 00000010", bus.req_valid_o, bus.req_addr_o);
        end
        repeat (3) cycle();
        checks++;
        if (pop_cnt != 4) begin
            errors++;
            $display("FAIL stall_drain: got %0d pops expected 4", pop_cnt);
        end
        repeat (6) cycle();
    endtask
    task automatic test_redirect();
        do_reset();
        lat = 3;
        bus.req_ready_i = 1'b1;
        for (int i = 0; i < 10 && mem_q.size() < 3; i++) cycle();
        checks++;
        if (mem_q.size() < 3) begin
            errors++;
            $display("FAIL inflight_timeout: got %0d in flight expected 3", mem_q.size());
        end
        bus.redirect_i = 1'b1;
        bus.redirect_pc_i = 32'h100;
        cycle();
        bus.redirect_i = 1'b0;
        got_valid = 1'b0;
        for (int i = 0; i < 20 && !got_valid; i++) cycle();
        checks++;
        if (!got_valid || first_pc !== 32'h100) begin
            errors++;
            $display("FAIL redirect_first_pc: got %h (valid seen %b) expected 00000100", first_pc, got_valid);
        end
        bus.redirect_i = 1'b1;
        bus.redirect_pc_i = 32'h203;
        cycle();
        bus.redirect_i = 1'b0;
        #1;
        checks++;
        if (bus.req_addr_o !== 32'h200) begin
            errors++;
            $display("FAIL redirect_align: got %h expected 00000200", bus.req_addr_o);
        end
        repeat (20) cycle();
    endtask
    task automatic test_wrap();
        do_reset();
        lat = 1;
        bus.req_ready_i = 1'b1;
        bus.redirect_i = 1'b1;
        bus.redirect_pc_i = 32'hFFFF_FFF8;
        cycle();
        bus.redirect_i = 1'b0;
        repeat (2) cycle();
        #1;
        checks++;
        if (bus.req_addr_o !== 32'h0) begin
            errors++;
            $display("FAIL pc_wrap: got %h expected 00000000", bus.req_addr_o);
        end
        repeat (8) cycle();
    endtask
    task automatic test_reset_midflight();
        do_reset();
        lat = 3;
        bus.req_ready_i = 1'b1;
        repeat (2) cycle();
        rst = 1'b1;
        bus.req_ready_i = 1'b0;
        cycle();
        rst = 1'b0;
        bus.resp_valid_i = 1'b0;
        #1;
        checks++;
        if (bus.valid_o !== 1'b0 || bus.instr_o !== 32'h13 || bus.outstanding_o !== 3'd0) begin
            errors++;
            $display("FAIL midflight_reset: got valid %b instr %h outstanding %0d expected 0 00000013 0", bus.valid_o, bus.instr_o, bus.outstanding_o);
        end
        for (int i = 0; i < 5; i++) begin
            cycle();
            #1;
            checks++;
            if (bus.valid_o !== 1'b0 || bus.outstanding_o !== 3'd0) begin
                errors++;
                $display("FAIL late_resp: got valid %b outstanding %0d expected 0 0", bus.valid_o, bus.outstanding_o);
            end
        end
        bus.req_ready_i = 1'b1;
        #1;
        checks++;
        if (bus.req_valid_o !== 1'b1 || bus.req_addr_o !== 32'h0) begin
            errors++;
            $display("FAIL restart_addr: got req_valid %b addr %h expected 1 00000000", bus.req_valid_o, bus.req_addr_o);
        end
        repeat (10) cycle();
    endtask
    initial begin
        bus.req_ready_i   = 1'b0;
        bus.resp_valid_i  = 1'b0;
        bus.resp_data_i   = 32'h0;
        bus.redirect_i    = 1'b0;
        bus.redirect_pc_i = 32'h0;
        bus.stall_i       = 1'b0;
        @(negedge clk);
        test_reset();
        test_stream();
        test_stall();
        test_redirect();
        test_wrap();
        test_reset_midflight();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
